// File: rtl/round_sequencer.sv
// Round controller for the Ascon permutation: sequences p^a / p^b passes,
// produces the round-constant index (UNROLL rounds per enabled cycle) and
// the first/last strobes used for input selection and the XOR stages.
module round_sequencer #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int UNROLL   = 1,
  parameter int CW       = 4
) (
  input  logic          clock_i,
  input  logic          resetb_i,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          hold_i,
  input  logic          abort_i,
  output logic [CW-1:0] round_o,
  output logic          ena_reg_o,
  output logic          first_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          mode_o
);

  // Parameter sanity: a pass must be a whole number of enabled cycles and
  // every round index must fit in round_o.
  if ((ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0) begin : g_bad_unroll
    $error("round_sequencer: UNROLL must divide ROUNDS_A and ROUNDS_B");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A) begin : g_bad_rounds_b
    $error("round_sequencer: need 1 <= ROUNDS_B <= ROUNDS_A");
  end
  if ((1 << CW) <= ROUNDS_A) begin : g_bad_cw
    $error("round_sequencer: CW too narrow for ROUNDS_A");
  end

  localparam logic [CW-1:0] START_A = '0;
  localparam logic [CW-1:0] START_B = CW'(ROUNDS_A - ROUNDS_B);
  localparam logic [CW-1:0] STEP    = CW'(UNROLL);
  // Index of the first round in the final enabled cycle of any pass.
  localparam logic [CW-1:0] LAST    = CW'(ROUNDS_A - UNROLL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          mode_q, mode_nxt;
  logic [CW-1:0] start_idx;
  logic          run;

  // Start index of the currently latched pass (p^b ends where p^a ends).
  assign start_idx = mode_q ? START_B : START_A;
  assign run       = (state == RUN);

  // State, count and latched mode registers.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state  <= IDLE;
      count  <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Next-state logic; abort wins over start and hold and leaves count alone.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mode_nxt  = mode_q;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start_i) begin
          state_nxt = RUN;
          count_nxt = mode_i ? START_B : START_A;
          mode_nxt  = mode_i;
        end
      end
      RUN: begin
        if (!hold_i) begin
          count_nxt = count + STEP;
          if (count == LAST) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i) begin
      state_nxt = IDLE;
      count_nxt = count;
      mode_nxt  = mode_q;
    end
  end

  // Outputs: decoded from state/count; only hold_i reaches the strobes
  // combinationally so a stall takes effect in the same cycle.
  always_comb begin
    ena_reg_o = run & ~hold_i;
    first_o   = run & ~hold_i & (count == start_idx);
    last_o    = run & ~hold_i & (count == LAST);
    busy_o    = run;
    done_o    = (state == DONE);
    round_o   = count;
    mode_o    = mode_q;
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: two instances (UNROLL=1 and UNROLL=2) exercised
// one at a time. The stimulus plans each pass from the round rules and queues
// the expected per-cycle response; a negedge monitor pops and compares.
module tb_round_sequencer;

  localparam int RA = 12;
  localparam int RB = 6;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [1:0] start = '0, mode = '0, hold = '0, abort = '0;
  logic [1:0][3:0] round;
  logic [1:0] ena, first, last, busy, done, modeo;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int sel  = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    bit dn;
    bit ena;
    int rnd;
    bit fst;
    bit lst;
    bit md;
  } entry_t;

  entry_t q[$];
  entry_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    round_sequencer #(.ROUNDS_A(RA), .ROUNDS_B(RB), .UNROLL(g + 1), .CW(4)) u_dut (
      .clock_i  (clk),
      .resetb_i (rstn),
      .start_i  (start[g]),
      .mode_i   (mode[g]),
      .hold_i   (hold[g]),
      .abort_i  (abort[g]),
      .round_o  (round[g]),
      .ena_reg_o(ena[g]),
      .first_o  (first[g]),
      .last_o   (last[g]),
      .busy_o   (busy[g]),
      .done_o   (done[g]),
      .mode_o   (modeo[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s dut=%0d cyc=%0d act=%0d exp=%0d", nm, sel, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk({nm, "_round"}, int'(round[g]), 0);
      chk({nm, "_ctl"}, int'({ena[g], first[g], last[g], busy[g], done[g], modeo[g]}), 0);
    end
  endtask

  // Monitor: every busy/done cycle of the selected DUT consumes one entry.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("other_idle", int'(busy[1-sel] | done[1-sel]), 0);
      if (busy[sel] || done[sel]) begin
        if (q.size() == 0) begin
          chk("unexpected_out", int'(busy[sel] | done[sel]), 0);
        end else begin
          e = q.pop_front();
          chk("cycle", cyc, e.cyc);
          chk("done", int'(done[sel]), int'(e.dn));
          chk("busy", int'(busy[sel]), int'(!e.dn));
          if (!e.dn) begin
            chk("round", int'(round[sel]), e.rnd);
            chk("ena", int'(ena[sel]), int'(e.ena));
            chk("first", int'(first[sel]), int'(e.fst));
            chk("last", int'(last[sel]), int'(e.lst));
          end
          chk("mode", int'(modeo[sel]), int'(e.md));
        end
      end else begin
        chk("ena_idle", int'(ena[sel] | first[sel] | last[sel]), 0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("missing_out", int'(busy[sel] | done[sel]), 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit dn, input bit en, input int r, input bit f, input bit l, input bit m);
    entry_t x;
    x.cyc = cyc; x.dn = dn; x.ena = en; x.rnd = r; x.fst = f; x.lst = l; x.md = m;
    q.push_back(x);
  endtask

  // One pass: start in the current (IDLE/DONE) cycle, walk the rounds with
  // optional holds and abort. Returns in the DONE cycle, or IDLE after abort.
  task automatic do_run(input bit m, input int abort_step, input int hold_at,
                        input int hold_len, input int hold_pct, input bit noise);
    int u, n, s, steps, nh, r;
    bit ab;
    u = sel + 1;
    n = m ? RB : RA;
    s = RA - n;
    steps = n / u;
    start[sel] = 1'b1;
    mode[sel]  = m;
    tick();
    start[sel] = 1'b0;
    mode[sel]  = 1'($urandom);
    for (int st = 0; st < steps; st++) begin
      r = s + st * u;
      nh = (st == hold_at) ? hold_len
         : (($urandom_range(99) < hold_pct) ? $urandom_range(1, 2) : 0);
      for (int h = 0; h < nh; h++) begin
        hold[sel]  = 1'b1;
        start[sel] = noise ? 1'($urandom) : 1'b0;
        mode[sel]  = 1'($urandom);
        push(1'b0, 1'b0, r, 1'b0, 1'b0, m);
        tick();
      end
      hold[sel]  = 1'b0;
      start[sel] = noise ? 1'($urandom) : 1'b0;
      ab = (st == abort_step);
      abort[sel] = ab;
      push(1'b0, 1'b1, r, st == 0, st == steps - 1, m);
      tick();
      abort[sel] = 1'b0;
      start[sel] = 1'b0;
      if (ab) return;
    end
    push(1'b1, 1'b0, 0, 1'b0, 1'b0, m);
  endtask

  task automatic random_runs(input int cnt);
    int steps;
    bit m;
    for (int i = 0; i < cnt; i++) begin
      m = 1'($urandom);
      steps = (m ? RB : RA) / (sel + 1);
      do_run(m, ($urandom_range(3) == 0) ? int'($urandom_range(steps - 1)) : -1,
             -1, 0, 25, 1'b1);
      if ($urandom_range(1) == 0) tick();
    end
    tick();
  endtask

  initial begin
    // Power-on reset: outputs cleared asynchronously, before any clock edge.
    #2 rstn = 1'b0;
    #2 chk_all_zero("por");
    #20;
    @(negedge clk) rstn = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("idle_after_por");
    mon_en = 1'b1;

    // UNROLL=1 directed passes.
    sel = 0;
    do_run(1'b0, -1, -1, 0, 0, 1'b0);           // plain p^a
    tick();
    do_run(1'b1, -1, -1, 0, 0, 1'b0);           // p^b
    do_run(1'b0, -1, -1, 0, 0, 1'b0);           // back-to-back p^a from DONE
    tick();
    do_run(1'b0, -1, 3, 2, 0, 1'b0);            // 2-cycle stall at round 3
    tick();
    do_run(1'b0, -1, 11, 2, 0, 1'b0);           // stall on the last round
    tick();
    do_run(1'b0, 5, 4, 1, 0, 1'b1);             // ignored starts, abort at 5
    tick();
    do_run(1'b0, 11, -1, 0, 0, 1'b0);           // abort with last_o
    tick();
    do_run(1'b1, 5, -1, 0, 0, 1'b0);            // p^b abort with last_o
    tick();
    random_runs(20);

    // Asynchronous reset in the middle of a p^b pass with mode_o=1.
    mon_en = 1'b0;
    start[0] = 1'b1; mode[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick(); tick();
    #2 rstn = 1'b0;
    #1 chk_all_zero("reset_mid_run");
    q.delete();
    @(negedge clk) rstn = 1'b1;
    tick(); tick();
    chk_all_zero("idle_after_reset");
    mon_en = 1'b1;

    // UNROLL=2 instance.
    sel = 1;
    tick();
    do_run(1'b0, -1, -1, 0, 0, 1'b0);
    tick();
    do_run(1'b1, -1, -1, 0, 0, 1'b0);
    do_run(1'b0, -1, 2, 1, 0, 1'b0);
    tick();
    do_run(1'b0, 5, -1, 0, 0, 1'b0);
    tick();
    random_runs(12);

    tick(); tick(); tick();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
